// File: rtl/sortnet_pkg.sv
// Shared types and helpers for the sorting-network drain.
package sortnet_pkg;

  localparam int KEY_W = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Low bit position of record idx inside a packed block of width-bit records.
  function automatic int rec_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/sortnet_blk_fifo.sv
// Synchronous block FIFO with wrap-bit pointers; read data is the head, combinationally.
module sortnet_blk_fifo import sortnet_pkg::*; #(
  parameter int BW        = 1024,
  parameter int DEPTH_LOG = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 wr_en,
  input  logic [BW-1:0]        wr_data,
  input  logic                 rd_en,
  output logic [BW-1:0]        rd_data,
  output logic [DEPTH_LOG:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int PW    = DEPTH_LOG + 1;

  logic [BW-1:0]    r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_do_wr;
  logic             w_do_rd;

  assign w_do_wr = wr_en && !full;
  assign w_do_rd = rd_en && !empty;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_wr) r_mem[r_wr_ptr[DEPTH_LOG-1:0]] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr[DEPTH_LOG-1:0]];
  assign count   = r_wr_ptr - r_rd_ptr;
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[DEPTH_LOG] != r_rd_ptr[DEPTH_LOG]) &&
                   (r_wr_ptr[DEPTH_LOG-1:0] == r_rd_ptr[DEPTH_LOG-1:0]);

endmodule

// File: rtl/sortnet_drain.sv
// Buffers sorted blocks from the network and serializes them one record per cycle.
// Optional key-order checker enabled by defining SORTNET_DRAIN_ORDER_CHECK_EN.
module sortnet_drain import sortnet_pkg::*; #(
  parameter int P_LOG     = 4,
  parameter int WIDTH     = 64,
  parameter int DEPTH_LOG = 2,
  parameter int SLACK     = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [(WIDTH<<P_LOG)-1:0] DIN,
  input  logic                      DINEN,
  output logic [WIDTH-1:0]          DOT,
  output logic                      DOTEN,
  input  logic                      DOT_RDY,
  output logic                      LAST,
  output logic                      SPACE_OK,
  output logic                      OVERFLOW,
  output logic                      ORDER_ERR
);

  localparam int NREC = 1 << P_LOG;
  localparam int BW   = WIDTH * NREC;
  localparam int CW   = DEPTH_LOG + 1;
  localparam int NDEP = 1 << DEPTH_LOG;
  localparam logic [P_LOG-1:0] IDX_MAX = P_LOG'(NREC - 1);

  logic             w_full, w_empty;
  logic [CW-1:0]    w_count, w_cnt_nxt;
  logic [BW-1:0]    w_rd_data;
  logic             w_wr, w_pop, w_hs, w_idx_last;
  logic [P_LOG-1:0] w_idx_inc;

  state_t           r_state, w_state_nxt;
  logic [BW-1:0]    r_blk, w_blk_nxt;
  logic [P_LOG-1:0] r_idx, w_idx_nxt;
  logic             r_doten, w_doten_nxt;
  logic [WIDTH-1:0] r_dot, w_dot_nxt;
  logic             r_last, w_last_nxt;
  logic             r_space_ok, r_overflow;

  sortnet_blk_fifo #(.BW(BW), .DEPTH_LOG(DEPTH_LOG)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (w_wr),
    .wr_data (DIN),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_wr       = DINEN && !w_full;
  assign w_hs       = r_doten && DOT_RDY;
  assign w_idx_last = (r_idx == IDX_MAX);
  assign w_idx_inc  = r_idx + P_LOG'(1);
  assign w_pop      = !w_empty &&
                      ((r_state == IDLE) || (r_state == SEND && w_hs && w_idx_last));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_blk   <= '0;
      r_idx   <= '0;
      r_doten <= 1'b0;
      r_dot   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_blk   <= w_blk_nxt;
      r_idx   <= w_idx_nxt;
      r_doten <= w_doten_nxt;
      r_dot   <= w_dot_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_state_nxt = SEND;
      SEND:    if (w_hs && w_idx_last && w_empty) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A pop on the final handshake reloads the block with no bubble.
  always_comb begin
    w_blk_nxt   = r_blk;
    w_idx_nxt   = r_idx;
    w_doten_nxt = r_doten;
    w_dot_nxt   = r_dot;
    w_last_nxt  = r_last;
    if (w_pop) begin
      w_blk_nxt   = w_rd_data;
      w_idx_nxt   = '0;
      w_doten_nxt = 1'b1;
      w_dot_nxt   = w_rd_data[rec_lo(0, WIDTH) +: WIDTH];
      w_last_nxt  = (IDX_MAX == '0);
    end else if (r_state == SEND && w_hs) begin
      if (!w_idx_last) begin
        w_idx_nxt  = w_idx_inc;
        w_dot_nxt  = r_blk[rec_lo(int'(w_idx_inc), WIDTH) +: WIDTH];
        w_last_nxt = (w_idx_inc == IDX_MAX);
      end else begin
        w_doten_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end
    end
  end

  assign w_cnt_nxt = w_count + CW'(w_wr) - CW'(w_pop);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_space_ok <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_space_ok <= (CW'(NDEP) - w_cnt_nxt) >= CW'(SLACK);
      if (DINEN && w_full) r_overflow <= 1'b1;
    end
  end

`ifdef SORTNET_DRAIN_ORDER_CHECK_EN
  logic [KEY_W-1:0] w_key_cur, w_key_nxt;
  logic             r_order_err;

  assign w_key_cur = r_dot[KEY_W-1:0];
  assign w_key_nxt = r_blk[rec_lo(int'(w_idx_inc), WIDTH) +: KEY_W];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_order_err <= 1'b0;
    end else if (r_state == SEND && w_hs && !w_idx_last && (w_key_cur > w_key_nxt)) begin
      r_order_err <= 1'b1;
    end
  end

  assign ORDER_ERR = r_order_err;
`else
  assign ORDER_ERR = 1'b0;
`endif

  assign DOT      = r_dot;
  assign DOTEN    = r_doten;
  assign LAST     = r_last;
  assign SPACE_OK = r_space_ok;
  assign OVERFLOW = r_overflow;

endmodule
